// File: rtl/insn_fetch_if.sv
// Fetch-stage bundle: instruction-memory port, redirect input and the
// valid/ready instruction stream toward the decoder.
interface insn_fetch_if #(
  parameter int unsigned XLEN = 64
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            insn_valid;
  logic [31:0]     insn;
  logic [XLEN-1:0] insn_pc;
  logic            insn_ready;

  modport master (
    output imem_req, imem_addr, insn_valid, insn, insn_pc,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, insn_ready
  );

  modport slave (
    input  imem_req, imem_addr, insn_valid, insn, insn_pc,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, insn_ready
  );
endinterface

// File: rtl/insn_fetch.sv
// Instruction fetch: PC, 1-cycle imem reads, small PC-tagged FIFO, redirect flush.
// Optional FETCH_PERF_CNT_EN adds a 64-bit accepted-instruction counter.
module insn_fetch #(
  parameter int unsigned      XLEN       = 64,
  parameter logic [XLEN-1:0]  RESET_PC   = '0,
  parameter int unsigned      FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  insn_fetch_if.master   bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0]    fetch_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {BOOT, FETCH, KILL} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     word;
  } entry_t;

  state_t          state, state_nx;
  logic            fetching, kill;
  logic [XLEN-1:0] pc, req_pc;
  logic            inflight;
  entry_t          mem [FIFO_DEPTH];
  entry_t          head, last;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     count;
  logic [AW+1:0]   occ;
  logic            pop, push, req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      BOOT:    state_nx = FETCH;
      FETCH:   if (bus.redirect_valid && inflight) state_nx = KILL;
      KILL:    state_nx = FETCH;
      default: state_nx = BOOT;
    endcase
  end

  always_comb begin
    fetching = 1'b0;
    kill     = 1'b0;
    case (state)
      FETCH:   fetching = 1'b1;
      KILL:    kill     = 1'b1;
      default: ;
    endcase
  end

  // A pop this cycle frees a slot, so steady state sustains one fetch per cycle.
  assign occ  = {1'b0, count} + {{(AW+1){1'b0}}, inflight} - {{(AW+1){1'b0}}, pop};
  assign req  = fetching & ~bus.redirect_valid & (occ < (AW+2)'(FIFO_DEPTH));
  assign pop  = bus.insn_valid & bus.insn_ready;
  // inflight gate drops any response not matched to a request since reset.
  assign push = bus.imem_rvalid & inflight & ~kill & ~bus.redirect_valid;

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc;
  assign head           = mem[rd_ptr];
  assign bus.insn_valid = (count != '0);
  assign bus.insn       = bus.insn_valid ? head.word : last.word;
  assign bus.insn_pc    = bus.insn_valid ? head.pc   : last.pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      last     <= '0;
    end else begin
      inflight <= req;
      if (bus.redirect_valid) pc <= bus.redirect_pc & ~(XLEN'(3));
      else if (req)           pc <= pc + XLEN'(4);
      if (req) req_pc <= pc;
      if (bus.insn_valid) last <= head;
      if (bus.redirect_valid) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: req_pc, word: bus.imem_rdata};
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    fetch_count <= '0;
    else if (pop) fetch_count <= fetch_count + 64'd1;
  end
`endif
endmodule

// File: tb/tb_insn_fetch.sv
// Directed bench for insn_fetch: boot timing, backpressure, redirects, PC wrap, async reset.
module tb_insn_fetch;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  insn_fetch_if #(.XLEN(XLEN)) bus();

`ifdef FETCH_PERF_CNT_EN
  logic [63:0] fetch_count;
`endif

  insn_fetch #(.XLEN(XLEN), .RESET_PC(64'h1000), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0013;
  endfunction

  // Memory answers exactly one cycle after each request; stray forces a bogus response.
  logic        mem_rv = 1'b0;
  logic [31:0] mem_rd = '0;
  logic        stray  = 1'b0;
  always @(posedge clk) begin
    mem_rv <= bus.imem_req;
    mem_rd <= word_of(bus.imem_addr);
  end
  assign bus.imem_rvalid = mem_rv | stray;
  assign bus.imem_rdata  = mem_rd;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          npop  = 0;
  logic [63:0] exp_pc;
  logic [63:0] held, last_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Every accepted instruction must be the next PC in program order with its word.
  task automatic cyc();
    #1;
    if (bus.insn_valid && bus.insn_ready) begin
      chk("pop_pc", bus.insn_pc, exp_pc);
      chk("pop_insn", bus.insn, word_of(exp_pc));
      exp_pc = exp_pc + 64'd4;
      npop++;
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.insn_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    exp_pc             = 64'h1000;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req",   bus.imem_req, 0);
    chk("rst_valid", bus.insn_valid, 0);
    chk("rst_insn",  bus.insn, 0);
    chk("rst_pc",    bus.insn_pc, 0);

    // boot: idle cycle, then sequential fetch
    reset = 1'b0;
    #1 chk("boot_req", bus.imem_req, 0); cyc();
    #1 chk("c1_req", bus.imem_req, 1); chk("c1_addr", bus.imem_addr, 64'h1000); cyc();
    #1 chk("c2_addr", bus.imem_addr, 64'h1004); chk("c2_valid", bus.insn_valid, 0); cyc();
    #1 chk("c3_valid", bus.insn_valid, 1); chk("c3_pc", bus.insn_pc, 64'h1000); cyc();
    repeat (4) begin #1 chk("steady_valid", bus.insn_valid, 1); cyc(); end

    // backpressure: FIFO fills to depth 2 and fetch stops
    held = exp_pc;
    bus.insn_ready = 1'b0;
    repeat (10) begin
      #1 chk("hold_req", bus.imem_req, 0);
      chk("hold_valid", bus.insn_valid, 1);
      chk("hold_pc", bus.insn_pc, held);
      cyc();
    end
    bus.insn_ready = 1'b1;
    #1 chk("rel_req", bus.imem_req, 1); chk("rel_addr", bus.imem_addr, held + 64'd8); cyc();
    #1 chk("rel_pc2", bus.insn_pc, held + 64'd4); cyc();
    repeat (3) begin #1 chk("rel_valid", bus.insn_valid, 1); cyc(); end

    // redirect with push, pop and a request in flight
    last_pc = exp_pc;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h2002;
    #1 chk("rd_req", bus.imem_req, 0); cyc();
    bus.redirect_valid = 1'b0;
    exp_pc = 64'h2000;
    #1 chk("kill_valid", bus.insn_valid, 0); chk("kill_req", bus.imem_req, 0);
    chk("kill_hold_pc", bus.insn_pc, last_pc); chk("kill_hold_insn", bus.insn, word_of(last_pc));
    cyc();
    #1 chk("rd_addr0", bus.imem_addr, 64'h2000); chk("rd_req1", bus.imem_req, 1);
    chk("rd_valid1", bus.insn_valid, 0); cyc();
    #1 chk("rd_addr1", bus.imem_addr, 64'h2004); chk("rd_valid2", bus.insn_valid, 0); cyc();
    #1 chk("rd_valid3", bus.insn_valid, 1); chk("rd_pc", bus.insn_pc, 64'h2000); cyc();
    repeat (2) cyc();

    // redirect with full FIFO and nothing in flight: no kill bubble
    bus.insn_ready = 1'b0;
    repeat (3) begin #1 chk("full_valid", bus.insn_valid, 1); cyc(); end
    bus.insn_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h3000;
    #1 chk("rd2_req", bus.imem_req, 0); cyc();
    bus.redirect_valid = 1'b0;
    exp_pc = 64'h3000;
    #1 chk("rd2_valid", bus.insn_valid, 0); chk("rd2_req1", bus.imem_req, 1);
    chk("rd2_addr", bus.imem_addr, 64'h3000); cyc();
    #1 chk("rd2_valid1", bus.insn_valid, 0); chk("rd2_addr1", bus.imem_addr, 64'h3004); cyc();
    #1 chk("rd2_pc", bus.insn_pc, 64'h3000); cyc();
    repeat (2) cyc();

    // PC wrap across 2^64, misaligned target forced to word alignment
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFB;
    #1 chk("wr_rd_req", bus.imem_req, 0); cyc();
    bus.redirect_valid = 1'b0;
    exp_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    #1 chk("wr_kill_req", bus.imem_req, 0); cyc();
    #1 chk("wr_a0", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFF8); cyc();
    #1 chk("wr_a1", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC); cyc();
    #1 chk("wr_a2", bus.imem_addr, 64'h0); chk("wr_p0", bus.insn_pc, 64'hFFFF_FFFF_FFFF_FFF8); cyc();
    #1 chk("wr_a3", bus.imem_addr, 64'h4); chk("wr_p1", bus.insn_pc, 64'hFFFF_FFFF_FFFF_FFFC); cyc();
    #1 chk("wr_p2", bus.insn_pc, 64'h0); cyc();

`ifdef FETCH_PERF_CNT_EN
    #1 chk("fetch_count", fetch_count, 64'(npop));
`endif

    // async reset mid-stream, stray response right after release
    #1 reset = 1'b1;
    #1 chk("ar_req", bus.imem_req, 0); chk("ar_valid", bus.insn_valid, 0);
    chk("ar_insn", bus.insn, 0); chk("ar_pc", bus.insn_pc, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("ar_count", fetch_count, 0);
`endif
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    exp_pc = 64'h1000;
    npop   = 0;
    stray  = 1'b1;
    #1 chk("ar_boot_req", bus.imem_req, 0); cyc();
    stray = 1'b0;
    #1 chk("ar_stray_valid", bus.insn_valid, 0); chk("ar_addr", bus.imem_addr, 64'h1000);
    chk("ar_req1", bus.imem_req, 1); cyc();
    #1 chk("ar_valid2", bus.insn_valid, 0); cyc();
    #1 chk("ar_valid3", bus.insn_valid, 1); chk("ar_pc3", bus.insn_pc, 64'h1000); cyc();
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
